// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns hazard-unit requests and data-memory
// busy into per-stage write/flush/bubble enables. It also keeps saturating
// per-class cycle counters and a sticky watchdog for long non-advancing runs.
module pipeline_stall_ctrl #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned WDOG_LIMIT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_has_hazard,
   input  logic             branch_hold,
   input  logic             redirect,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] freeze_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             wdog_err
);

   typedef enum logic [1:0] {
      C_RUN    = 2'b00,
      C_HOLD   = 2'b01,
      C_FREEZE = 2'b10,
      C_FLUSH  = 2'b11
   } cls_t;

   localparam int unsigned RW = $clog2(WDOG_LIMIT + 1);

   cls_t          cls;
   logic          redirect_pend;
   logic [RW-1:0] run_cnt;

   // Current-cycle class (priority: freeze, hold, flush, run) and stage controls
   always_comb begin
      cls         = C_RUN;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      if (dmem_busy) begin
         cls         = C_FREEZE;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         memwb_write = 1'b0;
      end else if (ld_has_hazard || branch_hold) begin
         cls         = C_HOLD;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else if (redirect || redirect_pend) begin
         cls        = C_FLUSH;
         ifid_flush = 1'b1;
      end
   end

   // Pending redirect captured during a freeze, consumed by the next flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_pend <= 1'b0;
      end else if (cls == C_FLUSH) begin
         redirect_pend <= 1'b0;
      end else if (cls == C_FREEZE && redirect) begin
         redirect_pend <= 1'b1;
      end
   end

   // Registered class of the previous cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_state <= 2'b00;
      end else begin
         ctrl_state <= cls;
      end
   end

   // Saturating per-class cycle counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         freeze_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (cls == C_HOLD && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (cls == C_FREEZE && freeze_cnt != '1) begin
            freeze_cnt <= freeze_cnt + CNT_W'(1);
         end
         if (cls == C_FLUSH && flush_cnt != '1) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   // Watchdog: count consecutive non-advancing cycles, flag on reaching the limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt  <= '0;
         wdog_err <= 1'b0;
      end else if (pc_write) begin
         run_cnt <= '0;
      end else if (run_cnt != RW'(WDOG_LIMIT)) begin
         run_cnt <= run_cnt + RW'(1);
         if (run_cnt == RW'(WDOG_LIMIT - 1)) begin
            wdog_err <= 1'b1;
         end
      end
   end

endmodule
